lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
// - Multi-cycle load/store sequencer between the pipeline memory stage and the data-memory bus.
// - Accepts loads (opcode 0000011) and stores (opcode 0100011); runs a req/gnt/rvalid handshake;
//   stalls the pipeline; aligns and extends load data; raises misalign, bus-error and timeout exceptions.
// - Sits beside the decode controller: it consumes the opcode and funct3 fields that the controller decodes.
// PARAMETERS
// - TIMEOUT    255  max cycles in REQ+WAIT before abort (>=2)
// - CNT_W      8    width of timeout counter, must hold TIMEOUT
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   reset, asynchronous, active-low
// - ex_valid      in   1   memory-stage instruction valid
// - instr_opcode  in   7   opcode of memory-stage instruction
// - funct3        in   3   width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - flush         in   1   squash memory-stage instruction
// - addr          in   32  effective address (ALU result)
// - wdata         in   32  store data (rs2)
// - stall         out  1   freeze pipeline
// - load_done     out  1   1-cycle pulse: rdata_out is valid for writeback
// - rdata_out     out  32  aligned, extended load data
// - misalign_exc  out  1   1-cycle pulse: misaligned access, no bus activity
// - bus_err_exc   out  1   1-cycle pulse: mem_err or timeout
// - mem_req/mem_we out 1   bus request / write
// - mem_addr      out  32  word address {addr[31:2],2'b00}
// - mem_be        out  4   byte enables
// - mem_wdata     out  32  lane-replicated store data
// - mem_gnt       in   1   request accepted
// - mem_rvalid    in   1   response valid (load data or store ack)
// - mem_rdata     in   32  load data
// - mem_err       in   1   error, qualified by mem_rvalid
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counter 0; flushed flag 0. Async assert clears mid-transaction.
// - FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
// - IDLE, ex_valid & ld/st & !flush:
//   - misaligned (H with addr[0]; W with addr[1:0]!=0): misalign_exc=1 (combinational), stall=0, stay IDLE.
//   - aligned: stall=1 (combinational); register addr, be, wdata, we, funct3; go REQ.
//   - unsupported funct3 or other opcode: no-op.
// - REQ: mem_req=1; mem_* held stable until mem_gnt; stall=1.
//   - gnt & !rvalid: go WAIT.
//   - gnt & rvalid in the same cycle (zero-wait): go DONE.
//   - flush before gnt: drop mem_req; go IDLE next cycle.
// - WAIT: stall=1; mem_req=0; on mem_rvalid go DONE.
//   - flush in WAIT (or in the REQ gnt cycle): set flushed; transaction completes with no load_done.
// - DONE: stall=0 (pipeline advances); load_done=1 for a load if !flushed & !error.
//   - bus_err_exc=1 if the response had mem_err, unless flushed.
//   - clear flushed; go IDLE.
// - rdata_out: registered on rvalid; holds until the next load.
//   - B/BU: lane addr[1:0], sign/zero-extend.
//   - H/HU: lane addr[1], sign/zero-extend.
//   - W: as-is.
// - Stores:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//   - SH: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
//   - SW: be=4'b1111.
//   - Loads drive be by the same rule; mem_we=0.
// - Timeout: counter cleared on entering REQ, increments in REQ/WAIT.
//   - count==TIMEOUT-1 without completion: drop mem_req, go DONE, bus_err_exc=1, no load_done.
//   - A late rvalid arriving in IDLE is ignored.
// - Stall count: 1 (accept) + REQ cycles + WAIT cycles. Minimum is 2.
// STRUCTURE
// - lsu_pkg:
//   - typedef enum {IDLE,REQ,WAIT,DONE} lsu_state_t
//   - OPC_LOAD/OPC_STORE localparams
//   - F3_B/H/W/BU/HU localparams
// - Sub-module lsu_align (combinational):
//   - misalign check, be/wdata lane generation, load extraction/extension.
// - Top level holds the FSM, the capture registers and the timeout counter.
// TESTING
// - SW addr 0x100 wdata 0xDEADBEEF, gnt in 3rd REQ cycle, rvalid next -> be=1111, we=1, stall 5 cycles, no load_done.
// - LB addr 0x103, rdata 0x80FF0000 -> rdata_out 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
// - LH addr 0x101 -> misalign_exc 1 cycle, mem_req never 1, stall 0.
// - LW with gnt & rvalid in 1st REQ cycle -> stall 2 cycles, load_done in DONE.
// - TIMEOUT=8, gnt never -> mem_req 8 cycles, then bus_err_exc 1 cycle, IDLE.
// - Flush in REQ before gnt -> IDLE next cycle.
// - Flush in WAIT -> completes, no load_done.
// - rst low in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store bus sequencer.
//   lsu_state_t   - sequencer states (IDLE, REQ, WAIT, DONE)
//   OPC_LOAD/OPC_STORE - major opcodes handled by the LSU
//   F3_*          - funct3 width/sign encodings
//   f3_supported  - true when funct3 is a legal width for the given access kind
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
// Request side (live memory-stage operands):
//   req_funct3, req_offset, req_wdata -> misalign, be, lane_wdata
// Response side (captured operands of the transaction in flight):
//   rsp_funct3, rsp_offset, rsp_rdata -> load_data (aligned, sign/zero-extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_wdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte enables and store data replication. Replicating the narrow store
  // data across all lanes lets the byte enables alone select the target lane.
  always_comb begin
    misalign   = 1'b0;
    be         = 4'b0000;
    lane_wdata = req_wdata;
    case (req_funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << req_offset;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        misalign   = req_offset[0];
        be         = 4'b0011 << req_offset;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        misalign = |req_offset;
        be       = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load extraction: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    case (rsp_offset)
      2'd0:    byte_lane = rsp_rdata[7:0];
      2'd1:    byte_lane = rsp_rdata[15:8];
      2'd2:    byte_lane = rsp_rdata[23:16];
      default: byte_lane = rsp_rdata[31:24];
    endcase
    half_lane = rsp_offset[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (rsp_funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'h000000, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'h0000, half_lane};
      default: load_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: multi-cycle load/store sequencer between the memory stage and
// the data-memory bus (req/gnt/rvalid handshake).
// Parameters: TIMEOUT - cycles allowed in REQ+WAIT before abort; CNT_W - counter width.
// Pipeline side: ex_valid, instr_opcode, funct3, flush, addr, wdata (in);
//                stall, load_done, rdata_out, misalign_exc, bus_err_exc (out).
// Bus side:      mem_req, mem_we, mem_addr, mem_be, mem_wdata (out);
//                mem_gnt, mem_rvalid, mem_rdata, mem_err (in).
// clk rising edge; rst asynchronous, active-low.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  instr_opcode,
  input  logic [2:0]  funct3,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_done,
  output logic [31:0] rdata_out,
  output logic        misalign_exc,
  output logic        bus_err_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  lsu_state_t       state_q, state_d;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             flushed_q;

  logic        is_load, is_store, mem_op, accept;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] lane_wdata, load_data;
  logic        timeout_hit, rsp_done, timeout_abort;

  lsu_align u_align (
    .req_funct3 (funct3),
    .req_offset (addr[1:0]),
    .req_wdata  (wdata),
    .misalign   (misalign),
    .be         (be),
    .lane_wdata (lane_wdata),
    .rsp_funct3 (f3_q),
    .rsp_offset (off_q),
    .rsp_rdata  (mem_rdata),
    .load_data  (load_data)
  );

  // A memory op is recognised only while out of reset, so asserting reset
  // forces stall low at once even if the stage still presents an instruction.
  assign is_load     = (instr_opcode == OPC_LOAD);
  assign is_store    = (instr_opcode == OPC_STORE);
  assign mem_op      = rst & ex_valid & ~flush & (is_load | is_store) &
                       f3_supported(is_store, funct3);
  assign accept      = (state_q == IDLE) & mem_op & ~misalign;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // A response completes the access either in the grant cycle (zero-wait) or in WAIT.
  assign rsp_done      = mem_rvalid & (((state_q == REQ) & mem_gnt) | (state_q == WAIT));
  // Reaching DONE from REQ/WAIT without a response can only mean a timeout.
  assign timeout_abort = (state_d == DONE) & ~rsp_done &
                         ((state_q == REQ) | (state_q == WAIT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs. In REQ, a flush without grant abandons
  // the request; once granted, the access must run to completion.
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    load_done    = 1'b0;
    misalign_exc = 1'b0;
    bus_err_exc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misalign) begin
            misalign_exc = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (flush && !mem_gnt)         state_d = IDLE;
        else if (mem_gnt && mem_rvalid) state_d = DONE;
        else if (timeout_hit)           state_d = DONE;
        else if (mem_gnt)               state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || timeout_hit) state_d = DONE;
      end
      DONE: begin
        load_done   = ~mem_we & ~flushed_q & ~err_q;
        bus_err_exc = err_q & ~flushed_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance; the bus fields stay stable until the
  // next accepted instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
    end else if (accept) begin
      mem_addr  <= {addr[31:2], 2'b00};
      mem_be    <= be;
      mem_wdata <= lane_wdata;
      mem_we    <= is_store;
      f3_q      <= funct3;
      off_q     <= addr[1:0];
    end
  end

  // Timeout counter: restarts at acceptance, runs while the access is open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       cnt_q <= '0;
    else if (accept)                                cnt_q <= '0;
    else if ((state_q == REQ) || (state_q == WAIT)) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Error and flush bookkeeping consumed in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      if (accept)             err_q <= 1'b0;
      else if (rsp_done)      err_q <= mem_err;
      else if (timeout_abort) err_q <= 1'b1;

      if (accept || state_q == DONE)                         flushed_q <= 1'b0;
      else if (flush && ((state_q == REQ && mem_gnt) || state_q == WAIT)) flushed_q <= 1'b1;
    end
  end

  // Load result register: updated only by a load response, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rdata_out <= 32'h0;
    else if (rsp_done && !mem_we) rdata_out <= load_data;
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed, self-checking bench for lsu_bus_ctrl (TIMEOUT=8).
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush;
  logic [6:0]  instr_opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_done, misalign_exc, bus_err_exc;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .instr_opcode(instr_opcode),
    .funct3(funct3), .flush(flush), .addr(addr), .wdata(wdata),
    .stall(stall), .load_done(load_done), .rdata_out(rdata_out),
    .misalign_exc(misalign_exc), .bus_err_exc(bus_err_exc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  // Load extension vectors, all against bus word 0x80FF0000.
  logic [2:0]  ld_f3   [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_W};
  logic [31:0] ld_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
  logic [3:0]  ld_be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                               32'hFFFF80FF, 32'h80FF0000};

  // Store lane vectors: SB 0x101 and SH 0x102 of 0x12345678.
  logic [2:0]  st_f3   [2] = '{F3_B, F3_H};
  logic [31:0] st_addr [2] = '{32'h101, 32'h102};
  logic [3:0]  st_be   [2] = '{4'b0010, 4'b1100};
  logic [31:0] st_data [2] = '{32'h78787878, 32'h56785678};

  task automatic clear_inputs();
    ex_valid = 1'b0; instr_opcode = 7'h0; funct3 = 3'h0; flush = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; instr_opcode = opc; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if ({stall, load_done, misalign_exc, bus_err_exc, mem_req, mem_we} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %06b expected 000000",
                         {stall, load_done, misalign_exc, bus_err_exc, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata, rdata_out} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: addr %h be %b wdata %h rdata %h expected all 0",
                         mem_addr, mem_be, mem_wdata, rdata_out);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release_idle: stall %b req %b expected 0 0", stall, mem_req);
    end
  endtask

  task automatic test_store_word();
    int stall_cycles = 0;
    @(negedge clk); issue(OPC_STORE, F3_W, 32'h100, 32'hDEADBEEF); #1;
    stall_cycles += int'(stall);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sw_accept_stall: got %b expected 1", stall); end
    @(negedge clk); clear_inputs(); #1;
    stall_cycles += int'(stall);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111) begin
      errors++; $display("[TB] FAIL sw_req_ctrl: req %b we %b be %b expected 1 1 1111", mem_req, mem_we, mem_be);
    end
    checks++;
    if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL sw_req_data: addr %h wdata %h expected 00000100 deadbeef", mem_addr, mem_wdata);
    end
    @(negedge clk); #1;
    stall_cycles += int'(stall);
    @(negedge clk); mem_gnt = 1'b1; #1;
    stall_cycles += int'(stall);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL sw_req_held: got %b expected 1", mem_req); end
    @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    stall_cycles += int'(stall);
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("[TB] FAIL sw_wait: req %b stall %b expected 0 1", mem_req, stall);
    end
    @(negedge clk); mem_rvalid = 1'b0; #1;
    stall_cycles += int'(stall);
    checks++;
    if (stall !== 1'b0 || load_done !== 1'b0 || bus_err_exc !== 1'b0) begin
      errors++; $display("[TB] FAIL sw_done: stall %b load_done %b err %b expected 0 0 0", stall, load_done, bus_err_exc);
    end
    checks++;
    if (stall_cycles != 5) begin errors++; $display("[TB] FAIL sw_stall_count: got %0d expected 5", stall_cycles); end
  endtask

  task automatic test_load_extend();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); issue(OPC_LOAD, ld_f3[i], ld_addr[i], 32'h0); #1;
      @(negedge clk); clear_inputs(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000; #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== ld_be[i] ||
          mem_addr !== (ld_addr[i] & 32'hFFFFFFFC)) begin
        errors++; $display("[TB] FAIL load_req_%0d: req %b we %b be %b addr %h expected 1 0 %b %h",
                           i, mem_req, mem_we, mem_be, mem_addr, ld_be[i], ld_addr[i] & 32'hFFFFFFFC);
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if (load_done !== 1'b1 || rdata_out !== ld_exp[i]) begin
        errors++; $display("[TB] FAIL load_data_%0d: done %b rdata %h expected 1 %h", i, load_done, rdata_out, ld_exp[i]);
      end
      @(negedge clk); #1;
      checks++;
      if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL load_pulse_%0d: got %b expected 0", i, load_done); end
    end
  endtask

  task automatic test_store_lanes();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); issue(OPC_STORE, st_f3[i], st_addr[i], 32'h12345678); #1;
      @(negedge clk); clear_inputs(); mem_gnt = 1'b1; mem_rvalid = 1'b1; #1;
      checks++;
      if (mem_be !== st_be[i] || mem_wdata !== st_data[i] || mem_we !== 1'b1) begin
        errors++; $display("[TB] FAIL store_lane_%0d: be %b wdata %h we %b expected %b %h 1",
                           i, mem_be, mem_wdata, mem_we, st_be[i], st_data[i]);
      end
      @(negedge clk); clear_inputs(); #1;
      checks++;
      if (load_done !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("[TB] FAIL store_done_%0d: done %b stall %b expected 0 0", i, load_done, stall);
      end
    end
  endtask

  task automatic test_misalign();
    int req_seen = 0;
    @(negedge clk); issue(OPC_LOAD, F3_H, 32'h101, 32'h0); #1;
    checks++;
    if (misalign_exc !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL misalign_lh: exc %b stall %b req %b expected 1 0 0", misalign_exc, stall, mem_req);
    end
    @(negedge clk); issue(OPC_STORE, F3_W, 32'h102, 32'h0); #1;
    checks++;
    if (misalign_exc !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL misalign_sw: exc %b stall %b expected 1 0", misalign_exc, stall);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_inputs(); #1;
      req_seen += int'(mem_req) + int'(misalign_exc);
    end
    checks++;
    if (req_seen != 0) begin errors++; $display("[TB] FAIL misalign_no_bus: got %0d active cycles expected 0", req_seen); end
  endtask

  task automatic test_zero_wait();
    int stall_cycles = 0;
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h200, 32'h0); #1;
    stall_cycles += int'(stall);
    @(negedge clk); clear_inputs(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    stall_cycles += int'(stall);
    @(negedge clk); clear_inputs(); #1;
    stall_cycles += int'(stall);
    checks++;
    if (load_done !== 1'b1 || rdata_out !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL zero_wait_done: done %b rdata %h expected 1 cafef00d", load_done, rdata_out);
    end
    checks++;
    if (stall_cycles != 2) begin errors++; $display("[TB] FAIL zero_wait_stall: got %0d expected 2", stall_cycles); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_cycles = 0;
    int done_cycles = 0;
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h300, 32'h0); #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); clear_inputs();
      if (i == 12) begin mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; end
      #1;
      req_cycles  += int'(mem_req);
      err_cycles  += int'(bus_err_exc);
      done_cycles += int'(load_done);
    end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (req_cycles != 8) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 8", req_cycles); end
    checks++;
    if (err_cycles != 1) begin errors++; $display("[TB] FAIL timeout_err_pulse: got %0d expected 1", err_cycles); end
    checks++;
    if (done_cycles != 0 || rdata_out !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL timeout_no_load: done %0d rdata %h expected 0 cafef00d", done_cycles, rdata_out);
    end
  endtask

  task automatic test_bus_error();
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h700, 32'h0); #1;
    @(negedge clk); clear_inputs(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b1; #1;
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (bus_err_exc !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("[TB] FAIL bus_err_done: err %b done %b expected 1 0", bus_err_exc, load_done);
    end
    @(negedge clk); #1;
    checks++;
    if (bus_err_exc !== 1'b0) begin errors++; $display("[TB] FAIL bus_err_pulse: got %b expected 0", bus_err_exc); end
  endtask

  task automatic test_flush_req();
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h400, 32'h0); #1;
    @(negedge clk); clear_inputs(); flush = 1'b1; #1;
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || load_done !== 1'b0 || bus_err_exc !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_req_idle: req %b stall %b done %b err %b expected 0 0 0 0",
                         mem_req, stall, load_done, bus_err_exc);
    end
  endtask

  task automatic test_flush_wait();
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h500, 32'h0); #1;
    @(negedge clk); clear_inputs(); mem_gnt = 1'b1; #1;
    @(negedge clk); clear_inputs(); flush = 1'b1; #1;
    @(negedge clk); clear_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_wait_stall: got %b expected 1", stall); end
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (load_done !== 1'b0 || bus_err_exc !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_wait_done: done %b err %b stall %b expected 0 0 0", load_done, bus_err_exc, stall);
    end
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h504, 32'h0); #1;
    @(negedge clk); clear_inputs(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55667788; #1;
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (load_done !== 1'b1 || rdata_out !== 32'h55667788) begin
      errors++; $display("[TB] FAIL flush_cleared: done %b rdata %h expected 1 55667788", load_done, rdata_out);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk); issue(OPC_LOAD, F3_W, 32'h600, 32'h0); #1;
    @(negedge clk); clear_inputs(); mem_gnt = 1'b1; #1;
    @(negedge clk); clear_inputs(); #1;
    rst = 1'b0; #1;
    checks++;
    if ({stall, load_done, misalign_exc, bus_err_exc, mem_req, mem_we} !== 6'b0 ||
        {mem_addr, mem_be, mem_wdata, rdata_out} !== '0) begin
      errors++; $display("[TB] FAIL reset_in_wait: stall %b req %b addr %h be %b rdata %h expected all 0",
                         stall, mem_req, mem_addr, mem_be, rdata_out);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); mem_rvalid = 1'b1; #1;
    @(negedge clk); clear_inputs(); #1;
    checks++;
    if (load_done !== 1'b0 || stall !== 1'b0 || rdata_out !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_late_rvalid: done %b stall %b rdata %h expected 0 0 0", load_done, stall, rdata_out);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_store_lanes();
    test_misalign();
    test_zero_wait();
    test_timeout();
    test_bus_error();
    test_flush_req();
    test_flush_wait();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
